seg7_scroll_engine: RTL and testbench

Parametrised multiplexed seven-segment driver that scrolls a message wider than the display across N_DIGITS common-cathode/anode digits. Message held in a writable register file, not fixed at elaboration. Supports hold/left/right/bounce scroll, two speeds, and blink. All timing derived from single-cycle enable strobes in the clk domain; no derived clocks. Sits between the board top level (switch/host writes) and the display pins.

---
 rtl/seg7_scroll_engine.sv | 157 +++++++++++++++
 tb/tb_seg7_scroll_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scroll_engine.sv
// Multiplexed seven-segment driver that scrolls a writable message across N_DIGITS digits.
// Optional macro SEG7_PWM_DIM_EN adds a dim[3:0] input that PWM-gates digit_en within each scan slot.
module seg7_scroll_engine #(
  parameter int N_DIGITS        = 4,
  parameter int MSG_LEN         = 18,
  parameter int MUX_DIV_LOG2    = 16,
  parameter int SCROLL_DIV_LOG2 = 24,
  parameter int BLINK_DIV_LOG2  = 22,
  parameter int SEG_ACTIVE_LOW  = 0,
  parameter int DIG_ACTIVE_LOW  = 1,
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic                speed,
  input  logic                blink_en,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [4:0]          wr_data,
`ifdef SEG7_PWM_DIM_EN
  input  logic [3:0]          dim,
`endif
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] digit_en,
  output logic                scroll_wrap
);

  localparam int DW0     = (MUX_DIV_LOG2 > SCROLL_DIV_LOG2) ? MUX_DIV_LOG2 : SCROLL_DIV_LOG2;
  localparam int DIV_W   = (DW0 > BLINK_DIV_LOG2) ? DW0 : BLINK_DIV_LOG2;
  localparam int IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int MAX_OFF = MSG_LEN - N_DIGITS;

  localparam logic [DIV_W-1:0]    ONES      = '1;
  localparam logic [DIV_W-1:0]    MUX_MASK  = ONES >> (DIV_W - MUX_DIV_LOG2);
  localparam logic [DIV_W-1:0]    SLOW_MASK = ONES >> (DIV_W - SCROLL_DIV_LOG2);
  localparam logic [DIV_W-1:0]    FAST_MASK = ONES >> (DIV_W - SCROLL_DIV_LOG2 + 1);
  localparam logic [DIV_W-1:0]    BLNK_MASK = ONES >> (DIV_W - BLINK_DIV_LOG2);
  localparam logic [6:0]          SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [N_DIGITS-1:0] DIG_OFF   = (DIG_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : '0;

  function automatic logic [6:0] glyph(input logic [4:0] code);
    case (code)
      5'h00: glyph = 7'h7E;  5'h01: glyph = 7'h30;  5'h02: glyph = 7'h6D;  5'h03: glyph = 7'h79;
      5'h04: glyph = 7'h33;  5'h05: glyph = 7'h5B;  5'h06: glyph = 7'h5F;  5'h07: glyph = 7'h70;
      5'h08: glyph = 7'h7F;  5'h09: glyph = 7'h7B;  5'h0A: glyph = 7'h77;  5'h0B: glyph = 7'h1F;
      5'h0C: glyph = 7'h4E;  5'h0D: glyph = 7'h3D;  5'h0E: glyph = 7'h4F;  5'h0F: glyph = 7'h47;
      5'h11: glyph = 7'h01;
      default: glyph = 7'h00;
    endcase
  endfunction

  logic [DIV_W-1:0]    div_q;
  logic [IW-1:0]       idx_q, idx_d;
  logic [AW-1:0]       off_q, off_d;
  logic                dir_q, dir_d;
  logic                phase_q, phase_d;
  logic                wrap_q, wrap_d;
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] dig_q, dig_d;
  logic [4:0]          msg_q [MSG_LEN];
  logic [AW:0]         rd_sum;
  logic [AW-1:0]       rd_addr;
  logic                mux_tick, scroll_tick, blink_tick, pwm_on;

  assign mux_tick    = (div_q & MUX_MASK) == MUX_MASK;
  assign scroll_tick = speed ? ((div_q & FAST_MASK) == FAST_MASK)
                             : ((div_q & SLOW_MASK) == SLOW_MASK);
  assign blink_tick  = (div_q & BLNK_MASK) == BLNK_MASK;

`ifdef SEG7_PWM_DIM_EN
  logic [3:0] pwm_q;
  // Inclusive compare: dim=0 lights the whole slot, dim=F leaves one count in sixteen.
  assign pwm_on = (pwm_q <= ~dim);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= '0;
    else        pwm_q <= pwm_q + 4'd1;
  end
`else
  assign pwm_on = 1'b1;
`endif

  always_comb begin
    off_d  = off_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    idx_d  = idx_q;
    if (mux_tick) idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    if (scroll_tick) begin
      case (mode)
        2'b01: if (off_q == AW'(MSG_LEN - 1)) begin off_d = '0; wrap_d = 1'b1; end
               else off_d = off_q + 1'b1;
        2'b10: if (off_q == '0) begin off_d = AW'(MSG_LEN - 1); wrap_d = 1'b1; end
               else off_d = off_q - 1'b1;
        2'b11: begin
          // dir_q=1 means counting up; an offset left beyond MAX by left/right mode snaps back.
          if (MAX_OFF == 0) off_d = '0;
          else if (off_q > AW'(MAX_OFF)) begin
            off_d = AW'(MAX_OFF); dir_d = 1'b0; wrap_d = 1'b1;
          end else if (dir_q) begin
            if (off_q == AW'(MAX_OFF)) begin off_d = AW'(MAX_OFF - 1); dir_d = 1'b0; wrap_d = 1'b1; end
            else off_d = off_q + 1'b1;
          end else begin
            if (off_q == '0) begin off_d = AW'(1); dir_d = 1'b1; wrap_d = 1'b1; end
            else off_d = off_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
    phase_d = blink_en ? (phase_q ^ blink_tick) : 1'b1;
    // Display uses next-state index/offset but the pre-write message contents.
    rd_sum  = {1'b0, off_d} + (AW+1)'(idx_d);
    rd_addr = (rd_sum >= (AW+1)'(MSG_LEN)) ? AW'(rd_sum - (AW+1)'(MSG_LEN)) : AW'(rd_sum);
    seg_d   = SEG_OFF;
    dig_d   = DIG_OFF;
    if (phase_d) begin
      seg_d = glyph(msg_q[rd_addr]) ^ SEG_OFF;
      if (pwm_on) dig_d = (N_DIGITS'(1) << idx_d) ^ DIG_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= 5'h10;
    end else if (wr_en && ({1'b0, wr_addr} < (AW+1)'(MSG_LEN))) begin
      msg_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      dir_q   <= 1'b1;
      phase_q <= 1'b1;
      wrap_q  <= 1'b0;
      seg_q   <= SEG_OFF;
      dig_q   <= DIG_OFF;
    end else begin
      div_q   <= div_q + 1'b1;
      idx_q   <= idx_d;
      off_q   <= off_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign seg         = seg_q;
  assign digit_en    = dig_q;
  assign scroll_wrap = wrap_q;

endmodule

// File: tb/tb_seg7_scroll_engine.sv
// Scoreboard bench for seg7_scroll_engine: stimulus queues expected outputs, a negedge monitor checks them.
module tb_seg7_scroll_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       speed = 1'b0;
  logic       blink_en = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic [6:0] seg;
  logic [3:0] digit_en;
  logic       scroll_wrap;
`ifdef SEG7_PWM_DIM_EN
  logic [3:0] dim = 4'h0;
`endif

  seg7_scroll_engine #(
    .N_DIGITS(4), .MSG_LEN(18), .MUX_DIV_LOG2(2), .SCROLL_DIV_LOG2(6),
    .BLINK_DIV_LOG2(4), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .speed(speed), .blink_en(blink_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef SEG7_PWM_DIM_EN
    .dim(dim),
`endif
    .seg(seg), .digit_en(digit_en), .scroll_wrap(scroll_wrap)
  );

  always #5 clk = ~clk;

  // Edges since reset release; scroll ticks land on multiples of 64 (32 when fast).
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Hex glyphs {a..g}; DASH is segment g only.
  localparam logic [6:0] G [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  localparam logic [6:0] DASH = 7'h01;

  typedef struct packed {
    logic [2:0] m;     // check seg / digit_en / scroll_wrap
    logic [6:0] seg;
    logic [3:0] dig;
    logic       wrap;
    logic       tmo;
  } exp_t;

  exp_t  eq[$];
  string nq[$];
  int    n_chk = 0;
  int    n_pass = 0;
  exp_t  me;
  string mn;
  bit    ok;

  always @(negedge clk) begin
    while (eq.size() > 0) begin
      me = eq.pop_front();
      mn = nq.pop_front();
      n_chk++;
      ok = !me.tmo;
      if (me.m[2] && seg !== me.seg) ok = 0;
      if (me.m[1] && digit_en !== me.dig) ok = 0;
      if (me.m[0] && scroll_wrap !== me.wrap) ok = 0;
      if (me.tmo)
        $display("FAIL %s: timed out waiting for digit select", mn);
      else if (!ok)
        $display("FAIL %s: got seg=%b digit_en=%b wrap=%b, want seg=%b digit_en=%b wrap=%b (mask %b)",
                 mn, seg, digit_en, scroll_wrap, me.seg, me.dig, me.wrap, me.m);
      else
        n_pass++;
    end
  end

  task automatic expect_out(input string nm, input logic [2:0] m, input logic [6:0] s,
                            input logic [3:0] d, input logic w);
    exp_t e;
    e.m = m; e.seg = s; e.dig = d; e.wrap = w; e.tmo = 1'b0;
    eq.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int per);
    int k;
    k = 0;
    do begin step(); k++; end while ((cyc % per) != 0 && k < 200);
  endtask

  task automatic wait_digit(input int i, input logic [6:0] s, input string nm);
    logic [3:0] d;
    bit found;
    exp_t e;
    d = ~(4'b0001 << i);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (digit_en === d) found = 1;
    end
    if (found) expect_out(nm, 3'b100, s, 4'h0, 1'b0);
    else begin
      e = '0; e.tmo = 1'b1;
      eq.push_back(e);
      nq.push_back(nm);
    end
  endtask

  initial begin
    #2;
    expect_out("reset_outputs", 3'b111, 7'h00, 4'hF, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    expect_out("first_scan_blank", 3'b111, 7'h00, 4'b1110, 1'b0);

    // Load symbols i mod 16, try two out-of-range addresses, then a dash at 0.
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 5'(i % 16);
      step();
    end
    wr_addr = 5'd18; wr_data = 5'h11; step();
    wr_addr = 5'd31; wr_data = 5'h11; step();
    wr_addr = 5'd0;  wr_data = 5'h11; step();
    wr_en = 1'b0;
    wait_digit(0, DASH,  "hold_d0_dash");
    wait_digit(1, G[1],  "hold_d1");
    wait_digit(2, G[2],  "oob_write_ignored");
    wait_digit(3, G[3],  "hold_d3");

    // Left scroll: offset t after tick t, wrap only on 17 -> 0.
    mode = 2'b01;
    for (int t = 1; t <= 18; t++) begin
      wait_tick(64);
      expect_out($sformatf("left_wrap_t%0d", t), 3'b001, 7'h00, 4'h0, t == 18);
      if (t == 1)  wait_digit(0, G[1], "left_t1_d0");
      if (t == 17) begin
        wait_digit(0, G[1], "left_off17_d0");
        wait_digit(1, DASH, "left_off17_d1_modwrap");
      end
      if (t == 18) wait_digit(0, DASH, "left_off0_d0");
    end

    // Bounce from 0 going up: 1..14, 13 (pulse), down to 0, 1 (pulse).
    mode = 2'b11;
    for (int t = 1; t <= 29; t++) begin
      wait_tick(64);
      expect_out($sformatf("bounce_wrap_t%0d", t), 3'b001, 7'h00, 4'h0, (t == 15) || (t == 29));
      if (t == 14) wait_digit(0, G[14], "bounce_off14");
      if (t == 15) wait_digit(0, G[13], "bounce_rev13");
      if (t == 28) wait_digit(0, DASH,  "bounce_off0");
      if (t == 29) wait_digit(0, G[1],  "bounce_rev1");
    end

    // Left from 1 up to 16, then enter bounce above MAX.
    mode = 2'b01;
    for (int u = 1; u <= 15; u++) begin
      wait_tick(64);
      expect_out($sformatf("left2_wrap_u%0d", u), 3'b001, 7'h00, 4'h0, 1'b0);
    end
    wait_digit(0, G[0], "left_off16_d0");
    mode = 2'b11;
    wait_tick(64);
    expect_out("enter_bounce_wrap", 3'b001, 7'h00, 4'h0, 1'b1);
    wait_digit(0, G[14], "enter_bounce_off14");
    wait_tick(64);
    expect_out("enter_bounce_down_nowrap", 3'b001, 7'h00, 4'h0, 1'b0);
    wait_digit(0, G[13], "enter_bounce_off13");

    // Right from 13 down to 0, then 0 -> 17 with a pulse.
    mode = 2'b10;
    for (int r = 1; r <= 14; r++) begin
      wait_tick(64);
      expect_out($sformatf("right_wrap_r%0d", r), 3'b001, 7'h00, 4'h0, r == 14);
      if (r == 13) wait_digit(0, DASH, "right_off0");
      if (r == 14) begin
        wait_digit(0, G[1], "right_off17_d0");
        wait_digit(1, DASH, "right_off17_d1");
      end
    end

    // Fast speed: next tick arrives on a 32-cycle boundary that is not a 64 one.
    mode = 2'b01; speed = 1'b1;
    wait_tick(32);
    expect_out("fast_tick_wrap", 3'b001, 7'h00, 4'h0, 1'b1);
    mode = 2'b00; speed = 1'b0;
    wait_digit(0, DASH, "fast_off0_d0");

    // Blink: phase flips every 16 cycles; scan index is 0 on those edges.
    blink_en = 1'b1;
    wait_tick(16);
    expect_out("blink_off", 3'b111, 7'h00, 4'hF, 1'b0);
    repeat (8) step();
    expect_out("blink_off_mid", 3'b111, 7'h00, 4'hF, 1'b0);
    wait_tick(16);
    expect_out("blink_on", 3'b111, DASH, 4'b1110, 1'b0);
    wait_tick(16);
    expect_out("blink_off2", 3'b111, 7'h00, 4'hF, 1'b0);
    blink_en = 1'b0;
    step();
    expect_out("blink_disable_resume", 3'b111, DASH, 4'b1110, 1'b0);

    // Asynchronous reset mid-cycle, held for three clocks.
    step();
    #2 rst_n = 1'b0;
    #1 expect_out("async_reset", 3'b111, 7'h00, 4'hF, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    expect_out("post_reset_d0_blank", 3'b111, 7'h00, 4'b1110, 1'b0);
    wait_digit(1, 7'h00, "post_reset_d1_blank");
    wait_digit(3, 7'h00, "post_reset_d3_blank");

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
